// File: rtl/synthesijer_shift_pkg.sv
// -----------------------------------------------------------------------------
// synthesijer_shift_pkg
// Shared definitions for the two-port shift arbiter:
//   shift_op_e   - 2-bit shift operation (logical right, arithmetic right,
//                  left, rotate right)
//   SHAMT_W      - width of the shift amount actually used (5 bits)
//   slot_t       - one pending request: operand, shift amount and operation
// -----------------------------------------------------------------------------
package synthesijer_shift_pkg;

    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        OP_SRL = 2'b00,   // logical right, zero fill
        OP_SRA = 2'b01,   // arithmetic right, sign fill
        OP_SLL = 2'b10,   // left, zero fill
        OP_ROR = 2'b11    // rotate right
    } shift_op_e;

    typedef struct packed {
        logic [31:0]        a;
        logic [SHAMT_W-1:0] shamt;
        shift_op_e          op;
    } slot_t;

endpackage

// File: rtl/synthesijer_shift_core32.sv
// -----------------------------------------------------------------------------
// synthesijer_shift_core32
// Purely combinational 32-bit shifter shared by both arbiter ports.
// Ports:
//   a       in  32  operand
//   shamt   in   5  shift amount
//   op      in   2  operation (shift_op_e)
//   result  out 32  shifted operand
// A shift amount of zero returns a unchanged for every operation.
// -----------------------------------------------------------------------------
module synthesijer_shift_core32
    import synthesijer_shift_pkg::*;
(
    input  logic [31:0]        a,
    input  logic [SHAMT_W-1:0] shamt,
    input  shift_op_e          op,
    output logic [31:0]        result
);

    // Complementary left-shift amount for the rotate. For shamt = 0 this is
    // 32, which shifts everything out and leaves the rotate equal to a.
    logic [SHAMT_W:0] rot_left_amt;

    always_comb begin
        rot_left_amt = 6'd32 - {1'b0, shamt};
        result       = a;
        case (op)
            OP_SRL:  result = a >> shamt;
            OP_SRA:  result = $unsigned($signed(a) >>> shamt);
            OP_SLL:  result = a << shamt;
            OP_ROR:  result = (a >> shamt) | (a << rot_left_amt);
            default: result = a;
        endcase
    end

endmodule

// File: rtl/synthesijer_shift_arbiter32.sv
// -----------------------------------------------------------------------------
// synthesijer_shift_arbiter32
// Two request ports share one combinational shifter. Each port owns a single
// pending slot; an arbiter grants one pending port per cycle and the shifter
// result is registered into that port's result register.
// Parameter:
//   FIXED_PRIO  0 = round-robin on ties, 1 = port 0 always wins ties
// Ports (N = 0, 1):
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-high reset
//   pN_a         in   32-bit operand
//   pN_b         in   shift amount, only [4:0] used
//   pN_op        in   operation (00 srl, 01 sra, 10 sll, 11 ror)
//   pN_nd        in   new-data strobe
//   pN_result    out  registered result, held until the next grant
//   pN_valid     out  one-cycle pulse the cycle after the grant
//   pN_busy      out  request pending, further nd is dropped
//   pN_ovf       out  sticky: nd arrived while busy
// Latency nd -> valid is 2 cycles uncontended, 3 for the losing port.
// -----------------------------------------------------------------------------
module synthesijer_shift_arbiter32
    import synthesijer_shift_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] p0_a,
    input  logic [31:0] p1_a,
    input  logic [31:0] p0_b,
    input  logic [31:0] p1_b,
    input  logic [1:0]  p0_op,
    input  logic [1:0]  p1_op,
    input  logic        p0_nd,
    input  logic        p1_nd,
    output logic [31:0] p0_result,
    output logic [31:0] p1_result,
    output logic        p0_valid,
    output logic        p1_valid,
    output logic        p0_busy,
    output logic        p1_busy,
    output logic        p0_ovf,
    output logic        p1_ovf
);

    // Per-port views of the request inputs
    logic [1:0]        nd_w;
    logic [1:0][31:0]  a_w;
    logic [1:0][31:0]  b_w;
    logic [1:0][1:0]   op_w;

    assign nd_w    = {p1_nd, p0_nd};
    assign a_w[0]  = p0_a;
    assign a_w[1]  = p1_a;
    assign b_w[0]  = p0_b;
    assign b_w[1]  = p1_b;
    assign op_w[0] = p0_op;
    assign op_w[1] = p1_op;

    // Only the low shift-amount bits matter; the rest are deliberately dropped.
    logic unused_b_hi;
    assign unused_b_hi = ^{p0_b[31:SHAMT_W], p1_b[31:SHAMT_W]};

    // State
    logic [1:0]  pend_q, pend_d;
    slot_t       slot_q [2];
    slot_t       slot_d [2];
    logic [31:0] res_q  [2];
    logic [31:0] res_d  [2];
    logic [1:0]  valid_q;
    logic [1:0]  ovf_q, ovf_d;
    logic        last_q, last_d;   // 1 = port 1 was granted most recently

    // Arbitration
    logic [1:0]  grant_w;
    logic        sel_w;
    logic [31:0] shift_res;

    always_comb begin
        grant_w = 2'b00;
        case (pend_q)
            2'b01: grant_w = 2'b01;
            2'b10: grant_w = 2'b10;
            2'b11: begin
                // Tie: port 0 wins under fixed priority, otherwise the port
                // that did not win last time.
                if ((FIXED_PRIO != 0) || last_q) begin
                    grant_w = 2'b01;
                end else begin
                    grant_w = 2'b10;
                end
            end
            default: grant_w = 2'b00;
        endcase
    end

    // With no grant the mux still selects slot 0; its output is simply unused.
    assign sel_w  = grant_w[1];
    assign last_d = (grant_w != 2'b00) ? grant_w[1] : last_q;

    synthesijer_shift_core32 u_core (
        .a      (slot_q[sel_w].a),
        .shamt  (slot_q[sel_w].shamt),
        .op     (slot_q[sel_w].op),
        .result (shift_res)
    );

    // Per-port next state. A grant requires a pending slot, and a load requires
    // an empty one, so the clear and the load never collide in the same cycle:
    // an nd during the grant cycle still sees busy high and is dropped.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            pend_d[i] = pend_q[i];
            slot_d[i] = slot_q[i];
            res_d[i]  = res_q[i];
            ovf_d[i]  = ovf_q[i];

            if (grant_w[i]) begin
                res_d[i]  = shift_res;
                pend_d[i] = 1'b0;
            end

            if (nd_w[i]) begin
                if (pend_q[i]) begin
                    ovf_d[i] = 1'b1;
                end else begin
                    pend_d[i]       = 1'b1;
                    slot_d[i].a     = a_w[i];
                    slot_d[i].shamt = b_w[i][SHAMT_W-1:0];
                    slot_d[i].op    = shift_op_e'(op_w[i]);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q  <= 2'b00;
            valid_q <= 2'b00;
            ovf_q   <= 2'b00;
            last_q  <= 1'b1;    // port 0 wins the first tie after reset
            for (int i = 0; i < 2; i++) begin
                slot_q[i] <= '0;
                res_q[i]  <= '0;
            end
        end else begin
            pend_q  <= pend_d;
            valid_q <= grant_w;
            ovf_q   <= ovf_d;
            last_q  <= last_d;
            for (int i = 0; i < 2; i++) begin
                slot_q[i] <= slot_d[i];
                res_q[i]  <= res_d[i];
            end
        end
    end

    assign p0_result = res_q[0];
    assign p1_result = res_q[1];
    assign p0_valid  = valid_q[0];
    assign p1_valid  = valid_q[1];
    assign p0_busy   = pend_q[0];
    assign p1_busy   = pend_q[1];
    assign p0_ovf    = ovf_q[0];
    assign p1_ovf    = ovf_q[1];

endmodule

// File: tb/tb_synthesijer_shift_arbiter32.sv
// -----------------------------------------------------------------------------
// tb_synthesijer_shift_arbiter32
// Drives a round-robin instance (index 0) and a fixed-priority instance
// (index 1) with identical stimulus and compares both against a behavioural
// model of the two-port shift service.
// -----------------------------------------------------------------------------
module tb_synthesijer_shift_arbiter32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  reset;
    logic [1:0][31:0]      a_s, b_s;
    logic [1:0][1:0]       op_s;
    logic [1:0]            nd_s;

    // Observed outputs indexed [instance][port]
    logic [1:0][1:0][31:0] res_o;
    logic [1:0][1:0]       val_o, busy_o, ovf_o;

    synthesijer_shift_arbiter32 #(.FIXED_PRIO(0)) u_rr (
        .clk(clk), .reset(reset),
        .p0_a(a_s[0]), .p1_a(a_s[1]), .p0_b(b_s[0]), .p1_b(b_s[1]),
        .p0_op(op_s[0]), .p1_op(op_s[1]), .p0_nd(nd_s[0]), .p1_nd(nd_s[1]),
        .p0_result(res_o[0][0]), .p1_result(res_o[0][1]),
        .p0_valid(val_o[0][0]), .p1_valid(val_o[0][1]),
        .p0_busy(busy_o[0][0]), .p1_busy(busy_o[0][1]),
        .p0_ovf(ovf_o[0][0]), .p1_ovf(ovf_o[0][1])
    );

    synthesijer_shift_arbiter32 #(.FIXED_PRIO(1)) u_fp (
        .clk(clk), .reset(reset),
        .p0_a(a_s[0]), .p1_a(a_s[1]), .p0_b(b_s[0]), .p1_b(b_s[1]),
        .p0_op(op_s[0]), .p1_op(op_s[1]), .p0_nd(nd_s[0]), .p1_nd(nd_s[1]),
        .p0_result(res_o[1][0]), .p1_result(res_o[1][1]),
        .p0_valid(val_o[1][0]), .p1_valid(val_o[1][1]),
        .p0_busy(busy_o[1][0]), .p1_busy(busy_o[1][1]),
        .p0_ovf(ovf_o[1][0]), .p1_ovf(ovf_o[1][1])
    );

    int n_vec = 0;
    int n_err = 0;

    // ---------------- behavioural model, [instance][port] ----------------
    logic [31:0] m_res  [2][2];
    bit          m_val  [2][2];
    bit          m_pend [2][2];
    bit          m_ovf  [2][2];
    logic [31:0] m_a    [2][2];
    logic [4:0]  m_sh   [2][2];
    logic [1:0]  m_op   [2][2];
    int          m_last [2];

    function automatic logic [31:0] ref_shift(logic [31:0] a, logic [4:0] s, logic [1:0] op);
        logic [31:0] r;
        int          si;
        si = int'(s);
        r  = '0;
        case (op)
            2'd0: r = a >> s;
            2'd1: r = a[31] ? ~((~a) >> s) : (a >> s);
            2'd2: r = a << s;
            default: for (int i = 0; i < 32; i++) r[i] = a[(i + si) % 32];
        endcase
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_last[k] = 1;
            for (int p = 0; p < 2; p++) begin
                m_res[k][p] = '0; m_val[k][p] = 0; m_pend[k][p] = 0; m_ovf[k][p] = 0;
                m_a[k][p] = '0; m_sh[k][p] = '0; m_op[k][p] = '0;
            end
        end
    endtask

    // State change at one rising edge, from the inputs present at that edge.
    task automatic model_edge();
        if (reset) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            bit old_pend [2];
            int g;
            old_pend[0] = m_pend[k][0];
            old_pend[1] = m_pend[k][1];
            g = -1;
            if (old_pend[0] && old_pend[1])
                g = (k == 1) ? 0 : (m_last[k] == 0 ? 1 : 0);
            else if (old_pend[0]) g = 0;
            else if (old_pend[1]) g = 1;
            for (int p = 0; p < 2; p++) m_val[k][p] = (g == p);
            if (g >= 0) begin
                m_res[k][g]  = ref_shift(m_a[k][g], m_sh[k][g], m_op[k][g]);
                m_pend[k][g] = 0;
                m_last[k]    = g;
            end
            for (int p = 0; p < 2; p++) begin
                if (nd_s[p]) begin
                    if (old_pend[p]) m_ovf[k][p] = 1;
                    else begin
                        m_pend[k][p] = 1;
                        m_a[k][p]    = a_s[p];
                        m_sh[k][p]   = b_s[p][4:0];
                        m_op[k][p]   = op_s[p];
                    end
                end
            end
        end
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 2; p++) begin
                check($sformatf("valid i%0d p%0d", k, p), 32'(val_o[k][p]),  32'(m_val[k][p]));
                check($sformatf("result i%0d p%0d", k, p), res_o[k][p],      m_res[k][p]);
                check($sformatf("busy i%0d p%0d", k, p),  32'(busy_o[k][p]), 32'(m_pend[k][p]));
                check($sformatf("ovf i%0d p%0d", k, p),   32'(ovf_o[k][p]),  32'(m_ovf[k][p]));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        nd_s = 2'b00;
    endtask

    task automatic req(int p, logic [31:0] a, logic [31:0] b, logic [1:0] op);
        a_s[p]  = a;
        b_s[p]  = b;
        op_s[p] = op;
        nd_s[p] = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int          cnt;
        int          seq [$];
        int          issued [2];
        logic [31:0] av;

        reset = 1'b1;
        a_s = '0; b_s = '0; op_s = '0; nd_s = '0;
        model_reset();

        // Reset state, with nd asserted during reset being ignored
        tick();
        req(0, 32'hDEADBEEF, 32'd3, 2'd0);
        tick();
        check("rst result p0", res_o[0][0], 32'h0);
        check("rst busy p0", 32'(busy_o[1][0]), 32'h0);
        reset = 1'b0;

        // Contention right after reset: port 0 first, port 1 one cycle later
        req(0, 32'h000000F0, 32'd4, 2'b00);
        req(1, 32'h00000001, 32'd31, 2'b10);
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("cont p0 valid i%0d", k), 32'(val_o[k][0]), 32'h1);
            check($sformatf("cont p0 result i%0d", k), res_o[k][0], 32'h0000000F);
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("cont p1 valid i%0d", k), 32'(val_o[k][1]), 32'h1);
            check($sformatf("cont p1 result i%0d", k), res_o[k][1], 32'h80000000);
        end
        tick();

        // Single arithmetic-right op on port 0
        req(0, 32'h80000000, 32'd4, 2'b01);
        tick();
        tick();
        check("sra valid", 32'(val_o[0][0]), 32'h1);
        check("sra result", res_o[0][0], 32'hF8000000);
        tick();

        // Tie with port 0 granted last: round-robin picks 1, fixed picks 0
        req(0, 32'h0000FF00, 32'd8, 2'b00);
        req(1, 32'h0000FF00, 32'd8, 2'b10);
        tick();
        tick();
        check("tie rr winner p1", 32'(val_o[0][1]), 32'h1);
        check("tie fp winner p0", 32'(val_o[1][0]), 32'h1);
        tick();
        tick();

        // Overflow: second nd on port 1 dropped, first operands used
        req(1, 32'h12345678, 32'd8, 2'b00);
        tick();
        req(1, 32'hFFFFFFFF, 32'd1, 2'b10);
        tick();
        cnt = int'(val_o[0][1]);
        check("ovf result", res_o[0][1], 32'h00123456);
        for (int i = 0; i < 4; i++) begin
            tick();
            cnt += int'(val_o[0][1]);
        end
        check("ovf single valid", 32'(cnt), 32'd1);
        check("ovf sticky", 32'(ovf_o[0][1]), 32'h1);

        // Boundaries: rotate with b = 33 uses shamt 1; shamt 0 returns a
        req(0, 32'h00000001, 32'd33, 2'b11);
        tick();
        tick();
        check("ror b33", res_o[0][0], 32'h80000000);
        for (int op = 0; op < 4; op++) begin
            av = $urandom | 32'h80000001;
            req(0, av, 32'hFFFFFFE0, 2'(op));
            tick();
            tick();
            check($sformatf("shamt0 op%0d", op), res_o[0][0], av);
        end

        // Round-robin alternation: each port re-requests whenever not busy
        do_reset();
        issued[0] = 0;
        issued[1] = 0;
        for (int c = 0; c < 60 && seq.size() < 16; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!m_pend[0][p] && issued[p] < 8) begin
                    req(p, $urandom, $urandom, 2'($urandom_range(0, 3)));
                    issued[p]++;
                end
            end
            tick();
            for (int p = 0; p < 2; p++) if (val_o[0][p]) seq.push_back(p);
        end
        check("rr grant count", 32'(seq.size()), 32'd16);
        foreach (seq[i]) check($sformatf("rr grant %0d", i), 32'(seq[i]), 32'(i % 2));
        tick();

        // Reset one cycle after nd: no valid, outputs cleared asynchronously
        req(0, 32'hA5A5A5A5, 32'd2, 2'b10);
        tick();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        req(0, 32'h00000010, 32'd1, 2'b00);
        req(1, 32'h00000010, 32'd1, 2'b00);
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("post-rst tie p0 i%0d", k), 32'(val_o[k][0]), 32'h1);
            check($sformatf("post-rst tie p1 i%0d", k), 32'(val_o[k][1]), 32'h0);
        end

        // Randomized traffic with occasional resets
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++) begin
                if ($urandom_range(0, 2) == 0)
                    req(p, $urandom, $urandom, 2'($urandom_range(0, 3)));
            end
            reset = ($urandom_range(0, 99) == 0);
            tick();
            reset = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
